// File: rtl/flag_status_reg.sv
// CPSR condition-flag register with banked SPSR, ARM condition evaluation and
// ALU carry-in return.
module flag_status_reg #(
    parameter bit BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_valid,
    input  logic       s_bit,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       msr_we,
    input  logic [3:0] msr_data,
    input  logic       exc_entry,
    input  logic       exc_return,
    input  logic       cond_valid,
    input  logic [3:0] cond,
    output logic [3:0] flags,
    output logic [3:0] spsr_flags,
    output logic       carry_out,
    output logic       cond_pass,
    output logic       cond_done,
    output logic       err_sticky
);

    localparam int unsigned FW = 4;

    logic [FW-1:0] flags_nxt;
    logic [FW-1:0] eval_flags;
    logic          ret_ok;
    logic          pass_nxt;

    // Evaluate a condition code against {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [FW-1:0] f);
        logic n, z, c, v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = ~(n ^ v);
            4'b1011: r = n ^ v;
            4'b1100: r = ~z & ~(n ^ v);
            4'b1101: r = z | (n ^ v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Next-flag selection; a return colliding with an entry is dropped.
    always_comb begin
        ret_ok    = exc_return & ~exc_entry;
        flags_nxt = flags;
        if (ret_ok) begin
            flags_nxt = spsr_flags;
        end else if (msr_we) begin
            flags_nxt = msr_data;
        end else if (alu_valid && s_bit) begin
            flags_nxt = {alu_n, alu_z, alu_c, alu_v};
        end
        eval_flags = BYPASS ? flags_nxt : flags;
        pass_nxt   = cond_eval(cond, eval_flags);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags      <= FW'(0);
            spsr_flags <= FW'(0);
            cond_pass  <= 1'b0;
            cond_done  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            flags     <= flags_nxt;
            cond_done <= cond_valid;
            if (exc_entry) begin
                spsr_flags <= flags;
            end
            if (cond_valid) begin
                cond_pass <= pass_nxt;
            end
            if (exc_entry && exc_return) begin
                err_sticky <= 1'b1;
            end
        end
    end

    // Carry-in comes from the register only, keeping the ALU path loop-free.
    assign carry_out = flags[1];

endmodule
